event_slot_manager: RTL and testbench
=====================================

Name: event_slot_manager

Overview:
- Parametrised slot and credit manager for the DDR frame buffer event path, in the aclk domain.
- Hands out free buffer slots to the event writer and queues completed events for readout.
- Gates readout on allow credits, requeues slots on nack, and frees slots on ack.
- Generalises the fixed 4-slot ack/nack/allow scheme to NSLOTS slots, with per-slot state tracking, protocol-error detection and initial credit.

Parameters:
- NSLOTS, 16, number of buffer slots; power of 2, 4..4096; AW = log2(NSLOTS).
- CREDIT_BITS, 9, width of the allow credit counter.
- INIT_CREDIT, 0, credit value loaded at reset.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- m_alloc_tdata  out  12  next free slot address (upper bits zero).
- m_alloc_tvalid  out  1  free slot available.
- m_alloc_tready  in  1  writer takes slot.
- s_done_tdata  in  32  {addr[11:0], len[19:0]} event fully written.
- s_done_tvalid  in  1
- s_done_tready  out  1
- s_ack_tdata  in  16  {allow, 3'b000, addr[11:0]}.
- s_ack_tvalid  in  1
- s_ack_tready  out  1
- s_nack_tdata  in  32  {addr[11:0], len[19:0]} replay request.
- s_nack_tvalid  in  1
- s_nack_tready  out  1
- m_event_tdata  out  32  {addr[11:0], len[19:0]} event to read out.
- m_event_tvalid  out  1
- m_event_tready  in  1
- allow_count_o  out  CREDIT_BITS  current credit.
- err_count_o  out  8  saturating protocol-error count.
- init_done_o  out  1  free list populated.

Behaviour:
- Reset values: all tvalid 0; all tready 0; allow_count_o = INIT_CREDIT; err_count_o 0; init_done_o 0; every slot FREE; length RAM contents don't-care.
- Init: after reset release, FSM INIT pushes slots 0..NSLOTS-1 into the free FIFO, one per cycle, then enters RUN and sets init_done_o.
  - Every tready stays 0 until RUN.
  - m_alloc_tvalid rises no earlier than cycle NSLOTS+1 after release.
- Slot states (2 bits per slot): FREE → ALLOC on alloc handshake; ALLOC → QUEUED on done; QUEUED → OUT on event handshake; OUT → QUEUED on nack; OUT → FREE on ack.
- Alloc: m_alloc presents the head of the free FIFO, registered. The FIFO is first-word-fall-through and depth NSLOTS, so it never overflows.
- Done: s_done_tready = 1 in RUN unless a nack is being accepted the same cycle. On handshake, store len in the length RAM and push addr into the readout FIFO (depth NSLOTS, cannot overflow since each slot is queued at most once).
  - If the slot is not ALLOC: drop the transfer, increment err_count_o.
- Nack: s_nack_tready = 1 in RUN. On handshake, if the slot is OUT, push addr into the readout FIFO; queued length = nack len if nonzero, else the stored len.
  - If the slot is not OUT: drop, err_count_o++.
  - Nack has priority over done for the single readout-FIFO write port.
- Ack: s_ack_tready = 1 in RUN. On handshake, if the slot is OUT, push addr into the free FIFO and set it FREE.
  - An ack with allow=1 increments credit whether or not the slot was valid. Allow acks are also used to prime credit, as in startup acks of slots 0..3.
  - Invalid slot: no free push, err_count_o++.
  - Ack on a slot address ≥ NSLOTS counts as an error.
- Event issue: m_event_tvalid = readout FIFO non-empty AND credit > 0, registered (1-cycle latency from push to tvalid).
  - On handshake: credit −1, slot → OUT, pop FIFO.
  - tdata holds stable while tvalid && !tready.
- Credit arithmetic:
  - Simultaneous allow-ack and event handshake → credit unchanged.
  - Increment saturates at 2^CREDIT_BITS−1.
  - Decrement only occurs with credit > 0.
- Free push arbitration: ack and init are the only free FIFO writers; they are mutually exclusive by state.
- err_count_o saturates at 255. Two errors in one cycle (done + ack) count +2.
- Asynchronous reset mid-operation returns to INIT: all queued and outstanding events are lost, and all outputs take their reset values immediately.

Test Plan:
- Reset, NSLOTS=16 → init_done_o at cycle 17; 16 alloc handshakes yield addresses 0..15 in order; 17th: m_alloc_tvalid=0.
- Alloc slot 0, done {0,100}, credit 0 → no m_event. Then ack(3, allow=1) → err_count_o=1, credit=1, m_event={0,100} next cycle; after handshake credit=0.
- Nack {0,3200} while slot 0 OUT, credit 1 → m_event={0,3200}. Then nack {0,0} → replay with len 100.
- Ack(0,1) with slot 0 OUT → slot 0 returns to the tail of the free FIFO, credit +1. A second ack(0,0) → err_count_o +1.
- Same cycle: nack on slot A and done on slot B → nack accepted, s_done_tready=0 for that cycle, B accepted the next cycle; readout order A then B.
- Credit saturation with CREDIT_BITS=3: nine allow-acks → allow_count_o=7. Allow-ack coincident with event handshake → unchanged. Assert aresetn low mid-stream → all outputs reset, INIT reruns.

Source files
------------

// File: rtl/event_slot_manager.sv
// Purpose : slot/credit manager for the DDR frame buffer event path; hands out
//           free slots, queues finished events, gates readout on allow credits.
// Latency : alloc and event outputs are registered; a readout-queue push shows
//           as m_event_tvalid one cycle later when credit is available.
// Backpressure: output registers hold tdata stable while tvalid && !tready;
//           s_done_tready drops for one cycle while a nack is being accepted.
// Ports   : aclk/aresetn; m_alloc_* free slot stream; s_done_* finished event;
//           s_ack_* {allow,3'b0,addr} release; s_nack_* replay request;
//           m_event_* readout stream; allow_count_o, err_count_o, init_done_o.

// First-word-fall-through FIFO; dout is valid whenever empty is low.
// Latency: push visible at dout on the next cycle.
// Backpressure: none; callers guarantee no push when full, no pop when empty.
module esm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module event_slot_manager #(
  parameter int NSLOTS      = 16,
  parameter int CREDIT_BITS = 9,
  parameter int INIT_CREDIT = 0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  output logic [11:0]            m_alloc_tdata,
  output logic                   m_alloc_tvalid,
  input  logic                   m_alloc_tready,
  input  logic [31:0]            s_done_tdata,
  input  logic                   s_done_tvalid,
  output logic                   s_done_tready,
  input  logic [15:0]            s_ack_tdata,
  input  logic                   s_ack_tvalid,
  output logic                   s_ack_tready,
  input  logic [31:0]            s_nack_tdata,
  input  logic                   s_nack_tvalid,
  output logic                   s_nack_tready,
  output logic [31:0]            m_event_tdata,
  output logic                   m_event_tvalid,
  input  logic                   m_event_tready,
  output logic [CREDIT_BITS-1:0] allow_count_o,
  output logic [7:0]             err_count_o,
  output logic                   init_done_o
);
  localparam int AW = $clog2(NSLOTS);
  localparam int RW = AW + 20;
  localparam logic [12:0] NSLOTS_W = 13'(NSLOTS);
  localparam logic [AW:0] INIT_END = (AW+1)'(NSLOTS);
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

  localparam logic [1:0] SLOT_FREE   = 2'd0;
  localparam logic [1:0] SLOT_ALLOC  = 2'd1;
  localparam logic [1:0] SLOT_QUEUED = 2'd2;
  localparam logic [1:0] SLOT_OUT    = 2'd3;

  typedef enum logic {ST_INIT, ST_RUN} fsm_t;

  fsm_t                   state;
  logic [AW:0]            init_cnt;
  logic                   run;
  logic [NSLOTS-1:0][1:0] slot_st;
  logic [19:0]            len_ram [NSLOTS];

  // ---------------- field decode ----------------
  logic [11:0]   done_addr, nack_addr, ack_addr;
  logic [19:0]   done_len, nack_len, nack_qlen;
  logic [AW-1:0] done_idx, nack_idx, ack_idx, alloc_idx, evt_idx;
  logic          ack_allow;
  logic          unused_ack_rsvd;

  assign done_addr = s_done_tdata[31:20];
  assign done_len  = s_done_tdata[19:0];
  assign nack_addr = s_nack_tdata[31:20];
  assign nack_len  = s_nack_tdata[19:0];
  assign ack_addr  = s_ack_tdata[11:0];
  assign ack_allow = s_ack_tdata[15];
  assign unused_ack_rsvd = ^s_ack_tdata[14:12];

  assign done_idx  = done_addr[AW-1:0];
  assign nack_idx  = nack_addr[AW-1:0];
  assign ack_idx   = ack_addr[AW-1:0];
  assign alloc_idx = m_alloc_tdata[AW-1:0];
  assign evt_idx   = m_event_tdata[20 +: AW];

  // ---------------- handshakes and slot checks ----------------
  logic alloc_hs, done_hs, nack_hs, ack_hs, evt_hs;
  logic done_ok, nack_ok, ack_ok;
  logic done_err, nack_err, ack_err;

  assign run           = (state == ST_RUN);
  assign s_nack_tready = run;
  assign s_ack_tready  = run;
  // The readout FIFO has one write port and nack owns it when both arrive.
  assign s_done_tready = run && !s_nack_tvalid;

  assign alloc_hs = m_alloc_tvalid && m_alloc_tready;
  assign done_hs  = s_done_tvalid && s_done_tready;
  assign nack_hs  = s_nack_tvalid && s_nack_tready;
  assign ack_hs   = s_ack_tvalid && s_ack_tready;
  assign evt_hs   = m_event_tvalid && m_event_tready;

  assign done_ok = done_hs && ({1'b0, done_addr} < NSLOTS_W) &&
                   (slot_st[done_idx] == SLOT_ALLOC);
  assign nack_ok = nack_hs && ({1'b0, nack_addr} < NSLOTS_W) &&
                   (slot_st[nack_idx] == SLOT_OUT);
  // A nack and an ack for the same outstanding slot in one cycle: the replay
  // wins and the ack is treated as stale, so the slot is never in both FIFOs.
  assign ack_ok  = ack_hs && ({1'b0, ack_addr} < NSLOTS_W) &&
                   (slot_st[ack_idx] == SLOT_OUT) &&
                   !(nack_ok && (nack_idx == ack_idx));

  assign done_err = done_hs && !done_ok;
  assign nack_err = nack_hs && !nack_ok;
  assign ack_err  = ack_hs && !ack_ok;

  // ---------------- free slot FIFO ----------------
  logic          init_push, free_push, free_pop, free_empty, alloc_load;
  logic [AW-1:0] free_din, free_head;

  assign init_push  = (state == ST_INIT) && (init_cnt != INIT_END);
  assign free_push  = init_push || ack_ok;
  assign free_din   = init_push ? init_cnt[AW-1:0] : ack_idx;
  assign alloc_load = run && !free_empty && (!m_alloc_tvalid || m_alloc_tready);
  assign free_pop   = alloc_load;

  esm_fifo #(.W(AW), .DEPTH(NSLOTS)) u_free_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (free_push),
    .din     (free_din),
    .pop     (free_pop),
    .dout    (free_head),
    .empty   (free_empty)
  );

  // ---------------- readout FIFO: {slot, length} ----------------
  logic          rdq_push, rdq_pop, rdq_empty, evt_load;
  logic [RW-1:0] rdq_din, rdq_head;
  logic [CREDIT_BITS-1:0] credit_held;

  // A zero nack length means "replay with the length the writer reported".
  assign nack_qlen = (nack_len != 20'd0) ? nack_len : len_ram[nack_idx];
  assign rdq_push  = nack_ok || done_ok;
  assign rdq_din   = nack_ok ? {nack_idx, nack_qlen} : {done_idx, done_len};

  // Credit consumed by an event leaving this cycle is not available for the
  // next load; a concurrent allow is only seen one cycle later.
  assign credit_held = CREDIT_BITS'(evt_hs);
  assign evt_load = run && !rdq_empty && (!m_event_tvalid || m_event_tready) &&
                    (allow_count_o > credit_held);
  assign rdq_pop  = evt_load;

  esm_fifo #(.W(RW), .DEPTH(NSLOTS)) u_rdq_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (rdq_push),
    .din     (rdq_din),
    .pop     (rdq_pop),
    .dout    (rdq_head),
    .empty   (rdq_empty)
  );

  always_ff @(posedge aclk) begin
    if (done_ok) len_ram[done_idx] <= done_len;
  end

  // ---------------- init FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      init_done_o <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == INIT_END) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- output registers ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_alloc_tvalid <= 1'b0;
      m_alloc_tdata  <= '0;
      m_event_tvalid <= 1'b0;
      m_event_tdata  <= '0;
    end else begin
      if (alloc_load) begin
        m_alloc_tvalid <= 1'b1;
        m_alloc_tdata  <= 12'(free_head);
      end else if (alloc_hs) begin
        m_alloc_tvalid <= 1'b0;
      end
      if (evt_load) begin
        m_event_tvalid <= 1'b1;
        m_event_tdata  <= {12'(rdq_head[RW-1:20]), rdq_head[19:0]};
      end else if (evt_hs) begin
        m_event_tvalid <= 1'b0;
      end
    end
  end

  // ---------------- per-slot state ----------------
  // Each source can only match a slot in its own expected state, so at most
  // one update lands on any given slot per cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      slot_st <= '0;
    end else begin
      if (alloc_hs) slot_st[alloc_idx] <= SLOT_ALLOC;
      if (done_ok)  slot_st[done_idx]  <= SLOT_QUEUED;
      if (evt_hs)   slot_st[evt_idx]   <= SLOT_OUT;
      if (nack_ok)  slot_st[nack_idx]  <= SLOT_QUEUED;
      if (ack_ok)   slot_st[ack_idx]   <= SLOT_FREE;
    end
  end

  // ---------------- credit and error counters ----------------
  logic       credit_inc;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign credit_inc = ack_hs && ack_allow;
  assign err_inc    = 2'(done_err) + 2'(nack_err) + 2'(ack_err);
  assign err_sum    = {1'b0, err_count_o} + {7'd0, err_inc};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      allow_count_o <= CREDIT_BITS'(INIT_CREDIT);
      err_count_o   <= '0;
    end else begin
      if (credit_inc && !evt_hs) begin
        if (allow_count_o != CREDIT_MAX) allow_count_o <= allow_count_o + 1'b1;
      end else if (evt_hs && !credit_inc) begin
        allow_count_o <= allow_count_o - 1'b1;
      end
      err_count_o <= err_sum[8] ? 8'hff : err_sum[7:0];
    end
  end
endmodule

// File: tb/tb_event_slot_manager.sv
module tb_event_slot_manager;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [11:0] m_alloc_tdata;
  logic        m_alloc_tvalid;
  logic        m_alloc_tready;
  logic [31:0] s_done_tdata;
  logic        s_done_tvalid;
  logic        s_done_tready;
  logic [15:0] s_ack_tdata;
  logic        s_ack_tvalid;
  logic        s_ack_tready;
  logic [31:0] s_nack_tdata;
  logic        s_nack_tvalid;
  logic        s_nack_tready;
  logic [31:0] m_event_tdata;
  logic        m_event_tvalid;
  logic        m_event_tready;
  logic [2:0]  allow_count_o;
  logic [7:0]  err_count_o;
  logic        init_done_o;

  event_slot_manager #(.NSLOTS(16), .CREDIT_BITS(3), .INIT_CREDIT(0)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .m_alloc_tdata  (m_alloc_tdata),
    .m_alloc_tvalid (m_alloc_tvalid),
    .m_alloc_tready (m_alloc_tready),
    .s_done_tdata   (s_done_tdata),
    .s_done_tvalid  (s_done_tvalid),
    .s_done_tready  (s_done_tready),
    .s_ack_tdata    (s_ack_tdata),
    .s_ack_tvalid   (s_ack_tvalid),
    .s_ack_tready   (s_ack_tready),
    .s_nack_tdata   (s_nack_tdata),
    .s_nack_tvalid  (s_nack_tvalid),
    .s_nack_tready  (s_nack_tready),
    .m_event_tdata  (m_event_tdata),
    .m_event_tvalid (m_event_tvalid),
    .m_event_tready (m_event_tready),
    .allow_count_o  (allow_count_o),
    .err_count_o    (err_count_o),
    .init_done_o    (init_done_o)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_bad = 0;

  // One clock cycle: inputs, then expected outputs (done_rdy before the edge,
  // the rest just after it).
  typedef struct packed {
    logic        dv;
    logic [31:0] dd;
    logic        av;
    logic [15:0] ad;
    logic        nv;
    logic [31:0] nd;
    logic        er;
    logic        x_drdy;
    logic        x_avld;
    logic [11:0] x_adat;
    logic        x_evld;
    logic [31:0] x_edat;
    logic [2:0]  x_allow;
    logic [7:0]  x_err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] ev(input logic [11:0] a, input logic [19:0] l);
    return {a, l};
  endfunction

  function automatic logic [31:0] ak(input logic al, input logic [11:0] a);
    return {16'd0, al, 3'b000, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input int dv, input int dd, input int av, input int ad,
                     input int nv, input int nd, input int er, input int x_drdy,
                     input int x_avld, input int x_adat, input int x_evld,
                     input int x_edat, input int x_allow, input int x_err);
    vec_t v;
    v.dv = dv[0];         v.dd = dd;              v.av = av[0];
    v.ad = ad[15:0];      v.nv = nv[0];           v.nd = nd;
    v.er = er[0];         v.x_drdy = x_drdy[0];   v.x_avld = x_avld[0];
    v.x_adat = x_adat[11:0];                      v.x_evld = x_evld[0];
    v.x_edat = x_edat;    v.x_allow = x_allow[2:0];
    v.x_err = x_err[7:0];
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    m_alloc_tready = 1'b0;
    s_done_tvalid  = 1'b0;  s_done_tdata = '0;
    s_ack_tvalid   = 1'b0;  s_ack_tdata  = '0;
    s_nack_tvalid  = 1'b0;  s_nack_tdata = '0;
    m_event_tready = 1'b0;
  endtask

  // Call at a negedge right after releasing reset; returns at posedge+1.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge aclk);
      #1;
      if (init_done_o) begin
        n = c;
        break;
      end
      check({tag, "_rdy_during_init"},
            32'({s_done_tready, s_ack_tready, s_nack_tready}), 0);
    end
    check({tag, "_init_cycles"}, n, 17);
    check({tag, "_alloc_vld_at_init_done"}, 32'(m_alloc_tvalid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    idle_inputs();
    aresetn = 1'b0;
    #1;
    check("rst_alloc_vld", 32'(m_alloc_tvalid), 0);
    check("rst_event_vld", 32'(m_event_tvalid), 0);
    check("rst_readies", 32'({s_done_tready, s_ack_tready, s_nack_tready}), 0);
    check("rst_allow", 32'(allow_count_o), 0);
    check("rst_err", 32'(err_count_o), 0);
    check("rst_init_done", 32'(init_done_o), 0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    wait_init("init");

    // Drain all 16 slots from the free list; expect 0..15 in order.
    m_alloc_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      @(negedge aclk);
      if (m_alloc_tvalid) begin
        check($sformatf("alloc_addr_%0d", got), 32'(m_alloc_tdata), got);
        got++;
      end
      @(posedge aclk);
      #1;
    end
    m_alloc_tready = 1'b0;
    check("alloc_count", got, 16);
    check("alloc_vld_when_empty", 32'(m_alloc_tvalid), 0);

    // All slots ALLOC, credit 0, err 0.
    //  dv dd           av ad         nv nd           er  drdy avld adat evld edat          alw err
    add(1, ev(0,100),   0, 0,         0, 0,           0,  1,   0, 0,    0, 0,             0, 0);
    add(0, 0,           0, 0,         0, 0,           0,  1,   0, 0,    0, 0,             0, 0);
    add(0, 0,           1, ak(1,3),   0, 0,           0,  1,   0, 0,    0, 0,             1, 1);
    add(0, 0,           0, 0,         0, 0,           0,  1,   0, 0,    1, ev(0,100),     1, 1);
    add(0, 0,           0, 0,         0, 0,           1,  1,   0, 0,    0, 0,             0, 1);
    add(0, 0,           1, ak(1,5),   0, 0,           0,  1,   0, 0,    0, 0,             1, 2);
    add(0, 0,           0, 0,         1, ev(0,3200),  0,  0,   0, 0,    0, 0,             1, 2);
    add(0, 0,           0, 0,         0, 0,           0,  1,   0, 0,    1, ev(0,3200),    1, 2);
    add(0, 0,           0, 0,         0, 0,           1,  1,   0, 0,    0, 0,             0, 2);
    add(0, 0,           1, ak(1,1),   1, ev(0,0),     0,  0,   0, 0,    0, 0,             1, 3);
    add(0, 0,           0, 0,         0, 0,           0,  1,   0, 0,    1, ev(0,100),     1, 3);
    add(0, 0,           0, 0,         0, 0,           1,  1,   0, 0,    0, 0,             0, 3);
    add(0, 0,           1, ak(1,0),   0, 0,           0,  1,   0, 0,    0, 0,             1, 3);
    add(0, 0,           1, ak(0,0),   0, 0,           0,  1,   1, 0,    0, 0,             1, 4);
    add(1, ev(2,222),   0, 0,         0, 0,           0,  1,   1, 0,    0, 0,             1, 4);
    add(0, 0,           0, 0,         0, 0,           0,  1,   1, 0,    1, ev(2,222),     1, 4);
    add(0, 0,           0, 0,         0, 0,           0,  1,   1, 0,    1, ev(2,222),     1, 4);
    add(0, 0,           0, 0,         0, 0,           1,  1,   1, 0,    0, 0,             0, 4);
    add(1, ev(4,444),   0, 0,         1, ev(2,0),     0,  0,   1, 0,    0, 0,             0, 4);
    add(1, ev(4,444),   0, 0,         0, 0,           0,  1,   1, 0,    0, 0,             0, 4);
    add(0, 0,           1, ak(1,6),   0, 0,           0,  1,   1, 0,    0, 0,             1, 5);
    add(0, 0,           0, 0,         0, 0,           0,  1,   1, 0,    1, ev(2,222),     1, 5);
    add(0, 0,           1, ak(1,7),   0, 0,           1,  1,   1, 0,    0, 0,             1, 6);
    add(0, 0,           0, 0,         0, 0,           0,  1,   1, 0,    1, ev(4,444),     1, 6);
    add(0, 0,           0, 0,         0, 0,           1,  1,   1, 0,    0, 0,             0, 6);
    add(1, ev(2,5),     1, ak(0,9),   0, 0,           0,  1,   1, 0,    0, 0,             0, 8);
    // Nine allow-acks on an out-of-range slot: credit saturates at 7.
    for (int i = 0; i < 9; i++)
      add(0, 0,         1, ak(1,100), 0, 0,           0,  1,   1, 0,    0, 0,
          (i < 7) ? i + 1 : 7, 9 + i);

    foreach (vq[i]) begin
      s_done_tvalid  = vq[i].dv;  s_done_tdata = vq[i].dd;
      s_ack_tvalid   = vq[i].av;  s_ack_tdata  = vq[i].ad;
      s_nack_tvalid  = vq[i].nv;  s_nack_tdata = vq[i].nd;
      m_event_tready = vq[i].er;
      @(negedge aclk);
      check($sformatf("v%0d_done_rdy", i), 32'(s_done_tready), 32'(vq[i].x_drdy));
      @(posedge aclk);
      #1;
      check($sformatf("v%0d_alloc_vld", i), 32'(m_alloc_tvalid), 32'(vq[i].x_avld));
      if (vq[i].x_avld)
        check($sformatf("v%0d_alloc_dat", i), 32'(m_alloc_tdata), 32'(vq[i].x_adat));
      check($sformatf("v%0d_event_vld", i), 32'(m_event_tvalid), 32'(vq[i].x_evld));
      if (vq[i].x_evld)
        check($sformatf("v%0d_event_dat", i), m_event_tdata, vq[i].x_edat);
      check($sformatf("v%0d_allow", i), 32'(allow_count_o), 32'(vq[i].x_allow));
      check($sformatf("v%0d_err", i), 32'(err_count_o), 32'(vq[i].x_err));
    end
    idle_inputs();

    // Asynchronous reset in the middle of the clock low phase.
    s_done_tvalid = 1'b1;
    s_done_tdata  = ev(10, 1010);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_alloc_vld", 32'(m_alloc_tvalid), 0);
    check("mid_rst_event_vld", 32'(m_event_tvalid), 0);
    check("mid_rst_readies", 32'({s_done_tready, s_ack_tready, s_nack_tready}), 0);
    check("mid_rst_allow", 32'(allow_count_o), 0);
    check("mid_rst_err", 32'(err_count_o), 0);
    check("mid_rst_init_done", 32'(init_done_o), 0);
    idle_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    wait_init("reinit");
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      if (m_alloc_tvalid) break;
    end
    check("reinit_alloc_vld", 32'(m_alloc_tvalid), 1);
    check("reinit_alloc_dat", 32'(m_alloc_tdata), 0);
    check("reinit_event_vld", 32'(m_event_tvalid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
